// File: rtl/mem_pkg.sv
// Load/store op encodings and helpers shared by the memory access stage.
package mem_pkg;

    localparam int LANES = 4;

    typedef enum logic [2:0] {
        MOP_LB  = 3'd0,
        MOP_LH  = 3'd1,
        MOP_LW  = 3'd2,
        MOP_SW  = 3'd3,
        MOP_LBU = 3'd4,
        MOP_LHU = 3'd5,
        MOP_SB  = 3'd6,
        MOP_SH  = 3'd7
    } mop_e;

    function automatic logic mop_is_load(input mop_e op);
        return op inside {MOP_LB, MOP_LH, MOP_LW, MOP_LBU, MOP_LHU};
    endfunction

endpackage

// File: rtl/mem_lane_ctl.sv
// Combinational byte-lane control: write enables, lane-replicated store data, misalign flag.
// Zero latency; no flow control.
module mem_lane_ctl
    import mem_pkg::*;
(
    input  mop_e             op,
    input  logic [1:0]       lo,
    input  logic [31:0]      wdata,
    output logic [LANES-1:0] we,
    output logic [31:0]      wdata_rep,
    output logic             misalign
);

    always_comb begin
        we        = '0;
        wdata_rep = wdata;
        misalign  = 1'b0;
        case (op)
            MOP_LW, MOP_SW:          misalign = (lo != 2'b00);
            MOP_LH, MOP_LHU, MOP_SH: misalign = lo[0];
            default:                 misalign = 1'b0;
        endcase
        case (op)
            MOP_SW: we = 4'b1111;
            MOP_SH: begin
                we        = lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            MOP_SB: begin
                we        = 4'b0001 << lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            default: we = '0;
        endcase
        // A misaligned store still occupies the BRAM slot but must not write.
        if (misalign) we = '0;
    end

endmodule

// File: rtl/mem_access_pipe.sv
// Load/store stage driving a synchronous BRAM; load writeback MEM_LAT+1 cycles after issue.
// One op per cycle, no backpressure; hazard flags in-flight loads for the issue logic.
module mem_access_pipe
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 17,
    parameter int REG_W   = 6,
    parameter int MEM_LAT = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [2:0]        in_op,
    input  logic [31:0]       in_base,
    input  logic [15:0]       in_imm,
    input  logic [31:0]       in_wdata,
    input  logic [REG_W-1:0]  in_dd,
    input  logic [REG_W-1:0]  q_rs,
    input  logic [REG_W-1:0]  q_rt,
    output logic              hazard,
    output logic [ADDR_W-1:0] d_addr,
    output logic [31:0]       d_wdata,
    output logic              d_en,
    output logic [LANES-1:0]  d_we,
    input  logic [31:0]       d_rdata,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_addr,
    output logic [31:0]       wb_data,
    output logic              wb_err
);

    localparam int L = MEM_LAT;

    mop_e             in_mop;
    logic             in_is_load;
    logic [31:0]      ea;
    logic             unused_ea_hi;
    logic [LANES-1:0] lane_we;
    logic [31:0]      lane_wdata;
    logic             lane_misalign;

    assign in_mop       = mop_e'(in_op);
    assign in_is_load   = mop_is_load(in_mop);
    assign ea           = in_base + {{16{in_imm[15]}}, in_imm};
    assign unused_ea_hi = ^ea[31:ADDR_W+2];

    mem_lane_ctl u_lane_ctl (
        .op        (in_mop),
        .lo        (ea[1:0]),
        .wdata     (in_wdata),
        .we        (lane_we),
        .wdata_rep (lane_wdata),
        .misalign  (lane_misalign)
    );

    // Per-stage load tracking; index 1 is the BRAM address stage.
    logic [L:1]            st_ld;
    logic [L:1]            st_err;
    logic [L:1][2:0]       st_op;
    logic [L:1][REG_W-1:0] st_dd;
    logic [L:1][1:0]       st_lo;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            d_en      <= 1'b0;
            d_we      <= '0;
            d_addr    <= '0;
            d_wdata   <= '0;
            st_ld[1]  <= 1'b0;
            st_err[1] <= 1'b0;
            st_op[1]  <= '0;
            st_dd[1]  <= '0;
            st_lo[1]  <= '0;
        end else begin
            d_en      <= in_valid;
            d_we      <= in_valid ? lane_we : '0;
            st_ld[1]  <= in_valid && in_is_load;
            st_err[1] <= lane_misalign;
            st_op[1]  <= in_op;
            st_dd[1]  <= in_dd;
            st_lo[1]  <= ea[1:0];
            if (in_valid) begin
                d_addr  <= ea[ADDR_W+1:2];
                d_wdata <= lane_wdata;
            end
        end
    end

    for (genvar g = 2; g <= L; g++) begin : g_stage
        always_ff @(posedge clk) begin
            if (!rstn) begin
                st_ld[g]  <= 1'b0;
                st_err[g] <= 1'b0;
                st_op[g]  <= '0;
                st_dd[g]  <= '0;
                st_lo[g]  <= '0;
            end else begin
                st_ld[g]  <= st_ld[g-1];
                st_err[g] <= st_err[g-1];
                st_op[g]  <= st_op[g-1];
                st_dd[g]  <= st_dd[g-1];
                st_lo[g]  <= st_lo[g-1];
            end
        end
    end

    mop_e        last_op;
    logic [1:0]  last_lo;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;
    logic        wb_fire;

    assign last_op = mop_e'(st_op[L]);
    assign last_lo = st_lo[L];
    assign wb_fire = st_ld[L] && (st_dd[L] != '0);

    always_comb begin
        rd_half = last_lo[1] ? d_rdata[31:16] : d_rdata[15:0];
        case (last_lo)
            2'd0:    rd_byte = d_rdata[7:0];
            2'd1:    rd_byte = d_rdata[15:8];
            2'd2:    rd_byte = d_rdata[23:16];
            default: rd_byte = d_rdata[31:24];
        endcase
        case (last_op)
            MOP_LB:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            MOP_LBU: rd_ext = {24'd0, rd_byte};
            MOP_LH:  rd_ext = {{16{rd_half[15]}}, rd_half};
            MOP_LHU: rd_ext = {16'd0, rd_half};
            MOP_LW:  rd_ext = d_rdata;
            default: rd_ext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_err   <= 1'b0;
        end else begin
            wb_valid <= wb_fire;
            if (wb_fire) begin
                wb_addr <= st_dd[L];
                wb_err  <= st_err[L];
                wb_data <= st_err[L] ? '0 : rd_ext;
            end
        end
    end

    // Register 0 never hazards: a zero dd never matches because it is excluded outright.
    always_comb begin
        hazard = in_valid && in_is_load && (in_dd != '0) && (in_dd == q_rs || in_dd == q_rt);
        for (int k = 1; k <= L; k++) begin
            if (st_ld[k] && (st_dd[k] != '0) && (st_dd[k] == q_rs || st_dd[k] == q_rt))
                hazard = 1'b1;
        end
    end

endmodule
